dbus_ram_responder: RTL and testbench

- Responder end of the data-bus (dbus) request/response protocol: receives dbus_req_t from the memory stage (loads, stores, page-table-walk reads) and answers with dbus_resp_t after a fixed, configurable latency.
- Backs requests with an internal 64-bit-word RAM.
- Used as the simulation/SoC-local data memory and as the bench-side model for memory-stage and translate verification.

---
 rtl/dbus_ram_responder.sv | 152 +++++++++++++++
 tb/tb_dbus_ram_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_ram_responder.sv
// Data-bus responder backed by a 64-bit-word RAM: accepts one dbus request,
// answers it a fixed LATENCY cycles later, and counts completed reads/writes.
package dbus_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
endpackage

module dbus_ram_responder
  import dbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        fault,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output resp_state_t state
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [63:0] SPAN  = 64'(MEM_WORDS) << 3;

  // Handshake: the initiator raises dreq.valid and holds it until the one-cycle
  // addr_ok/data_ok pulse; dropping valid before that pulse abandons the request.
  resp_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              in_range_q;
  logic [7:0]        strobe_q;
  logic [63:0]       data_q;
  logic [63:0]       offset;
  logic              in_range;
  logic              accept;
  logic              complete;
  logic              commit;
  logic [63:0]       mem [MEM_WORDS];
  logic              unused_bits;

  // The offset compare stays correct even if BASE_ADDR + SPAN would overflow.
  assign offset   = dreq.addr - BASE_ADDR;
  assign in_range = (dreq.addr >= BASE_ADDR) && (offset < SPAN);
  assign accept   = (state_q == IDLE) && dreq.valid;
  assign complete = (state_q == RESP) && dreq.valid;
  assign commit   = complete && in_range_q && (|strobe_q);
  assign state    = state_q;

  assign unused_bits = ^{dreq.size, offset[2:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Later changes to the request fields are ignored; only this copy is used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      in_range_q <= 1'b0;
      strobe_q   <= '0;
      data_q     <= '0;
    end else if (accept) begin
      idx_q      <= offset[IDX_W+2:3];
      in_range_q <= in_range;
      strobe_q   <= dreq.strobe;
      data_q     <= dreq.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (complete) begin
      if (|strobe_q) wr_count <= wr_count + 32'd1;
      else           rd_count <= rd_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  // Read data is the word as it stood before this cycle's byte merge.
  always_comb begin
    dresp = '0;
    fault = 1'b0;
    if (complete) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = in_range_q ? mem[idx_q] : 64'h0;
      fault         = !in_range_q;
    end
  end

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder: vector table on a LATENCY=2 instance,
// plus abort, back-to-back (LATENCY=1 and 5) and asynchronous reset sequences.
module tb_dbus_ram_responder;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset = 1'b0;

  dbus_req_t   dreq, dreq1, dreq5;
  dbus_resp_t  dresp, dresp1, dresp5;
  logic        fault, fault1, fault5;
  logic [31:0] rd_count, wr_count, rd_count1, wr_count1, rd_count5, wr_count5;
  resp_state_t state, state1, state5;

  int checks = 0;
  int errors = 0;

  always #5 if (clk_en) clk = ~clk;

  dbus_ram_responder #(.LATENCY(2)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .fault(fault),
    .rd_count(rd_count), .wr_count(wr_count), .state(state));
  dbus_ram_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .fault(fault1),
    .rd_count(rd_count1), .wr_count(wr_count1), .state(state1));
  dbus_ram_responder #(.LATENCY(5)) dut5 (
    .clk(clk), .reset(reset), .dreq(dreq5), .dresp(dresp5), .fault(fault5),
    .rd_count(rd_count5), .wr_count(wr_count5), .state(state5));

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic        chk;
    logic [63:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request on the LATENCY=2 instance and holds it until data_ok.
  task automatic do_req(input logic [63:0] addr, input logic [7:0] strobe,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic rfault, output logic aok, output int lat);
    logic seen;
    seen = 1'b0; lat = 0; rdata = '0; rfault = 1'b0; aok = 1'b0;
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = addr; dreq.strobe = strobe; dreq.data = wdata;
    dreq.size = MSIZE8;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dresp.data_ok) begin
        seen = 1'b1; lat = i; rdata = dresp.data; rfault = fault; aok = dresp.addr_ok;
        break;
      end
    end
    if (seen) begin
      @(posedge clk); #1;
    end
    dreq.valid = 1'b0;
  endtask

  initial begin
    logic [63:0] rdata;
    logic        rfault, aok, seen;
    int          lat, exp_rd, exp_wr;
    logic        exp1, exp5;

    dreq = '0; dreq1 = '0; dreq5 = '0;
    vecs[0]  = '{64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{64'h8000_0010, 8'h00, 64'h0, 1'b1, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{64'h8000_0010, 8'h08, 64'h00000000AB000000, 1'b1, 64'h1122334455667788, 1'b0};
    vecs[3]  = '{64'h8000_0013, 8'h00, 64'h0, 1'b1, 64'h11223344AB667788, 1'b0};
    vecs[4]  = '{64'h8000_0000, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b0};
    vecs[5]  = '{64'h8000_7FF8, 8'hFF, 64'hCAFEF00DDEADBEEF, 1'b0, 64'h0, 1'b0};
    vecs[6]  = '{64'h7FFF_FFF8, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[7]  = '{64'h7FFF_FFF8, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b1};
    vecs[8]  = '{64'h8000_8000, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[9]  = '{64'h8000_8000, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b1};
    vecs[10] = '{64'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF, 1'b0};
    vecs[11] = '{64'h8000_7FF8, 8'h00, 64'h0, 1'b1, 64'hCAFEF00DDEADBEEF, 1'b0};
    vecs[12] = '{64'h8000_0000, 8'h0F, 64'h0000000055AA55AA, 1'b1, 64'h0123456789ABCDEF, 1'b0};
    vecs[13] = '{64'h8000_0004, 8'h00, 64'h0, 1'b1, 64'h0123456755AA55AA, 1'b0};

    // Reset state
    #12;
    check("rst_data_ok", dresp.data_ok, 0);
    check("rst_addr_ok", dresp.addr_ok, 0);
    check("rst_data", dresp.data, 0);
    check("rst_fault", fault, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_state", 64'(state), 64'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Vector table
    exp_rd = 0; exp_wr = 0;
    for (int v = 0; v < 14; v++) begin
      do_req(vecs[v].addr, vecs[v].strobe, vecs[v].wdata, rdata, rfault, aok, lat);
      if (vecs[v].strobe == 8'h00) exp_rd++; else exp_wr++;
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'd2);
      check($sformatf("vec%0d_addr_ok", v), aok, 1);
      check($sformatf("vec%0d_fault", v), rfault, vecs[v].exp_fault);
      if (vecs[v].chk) check($sformatf("vec%0d_data", v), rdata, vecs[v].exp_data);
    end
    check("table_rd_count", rd_count, 64'(exp_rd));
    check("table_wr_count", wr_count, 64'(exp_wr));

    // Abort in WAIT: valid dropped right after acceptance
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'hFF; dreq.data = 64'h0;
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dresp.data_ok) seen = 1'b1;
    end
    check("abort_wait_no_data_ok", seen, 0);
    check("abort_wait_state", 64'(state), 64'(IDLE));
    check("abort_wait_wr_count", wr_count, 64'(exp_wr));

    // Abort in RESP: valid dropped during the response cycle
    @(negedge clk);
    dreq.valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_resp_pulse_before_drop", dresp.data_ok, 1);
    dreq.valid = 1'b0;
    #1;
    check("abort_resp_data_ok", dresp.data_ok, 0);
    check("abort_resp_addr_ok", dresp.addr_ok, 0);
    check("abort_resp_data", dresp.data, 0);
    @(posedge clk); #1;
    check("abort_resp_state", 64'(state), 64'(IDLE));
    check("abort_resp_wr_count", wr_count, 64'(exp_wr));
    do_req(64'h8000_0010, 8'h00, 64'h0, rdata, rfault, aok, lat);
    exp_rd++;
    check("abort_word_unchanged", rdata, 64'h11223344AB667788);
    check("abort_rd_count", rd_count, 64'(exp_rd));

    // Back-to-back reads with valid held, LATENCY=1 and LATENCY=5 side by side
    @(negedge clk);
    dreq1.valid = 1'b1; dreq1.addr = 64'h8000_0020; dreq1.strobe = 8'h00;
    dreq5.valid = 1'b1; dreq5.addr = 64'h8000_0020; dreq5.strobe = 8'h00;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      exp1 = (i <= 6) && (i % 2 == 1);
      exp5 = (i % 6 == 5);
      check($sformatf("b2b_lat1_edge%0d", i), dresp1.data_ok, exp1);
      check($sformatf("b2b_lat5_edge%0d", i), dresp5.data_ok, exp5);
      if (i == 6) dreq1.valid = 1'b0;
      if (i == 18) dreq5.valid = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("b2b_lat1_rd_count", rd_count1, 3);
    check("b2b_lat5_rd_count", rd_count5, 3);
    check("b2b_lat1_fault", fault1, 0);
    check("b2b_lat5_state", 64'(state5), 64'(IDLE));

    // Asynchronous reset in the WAIT cycle of a write, with the clock stopped
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'hFF;
    dreq.data = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    check("mid_rst_in_wait", 64'(state), 64'(WAIT));
    @(negedge clk);
    clk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_data_ok", dresp.data_ok, 0);
    check("mid_rst_addr_ok", dresp.addr_ok, 0);
    check("mid_rst_fault", fault, 0);
    check("mid_rst_state", 64'(state), 64'(IDLE));
    check("mid_rst_rd_count", rd_count, 0);
    check("mid_rst_wr_count", wr_count, 0);
    check("mid_rst_rd_count5", rd_count5, 0);
    dreq.valid = 1'b0;
    #1 reset = 1'b1;
    #1 clk_en = 1'b1;
    do_req(64'h8000_0010, 8'h00, 64'h0, rdata, rfault, aok, lat);
    check("post_rst_latency", 64'(lat), 2);
    check("post_rst_word_unchanged", rdata, 64'h11223344AB667788);
    check("post_rst_rd_count", rd_count, 1);
    check("post_rst_wr_count", wr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
